xor5_parity_sched: RTL and testbench
====================================

XOR5_PARITY_SCHED -- requirements
Module: xor5_parity_sched

Interface
REQ-001 The block SHALL have parameter WORD_W, default 20: request word width in bits, a multiple of 5.
REQ-002 The block SHALL have parameter NREQ, default 2: number of requesters, range 2..4.
REQ-003 The block SHALL have derived constants NCHUNK = WORD_W/5 and IDW = max(1, clog2(NREQ)).
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port req_valid, input, NREQ bits: per-requester word valid.
REQ-008 Port req_data, input, NREQ*WORD_W bits: per-requester word; requester i uses slice [i*WORD_W +: WORD_W].
REQ-009 Port req_ready, output, NREQ bits: one-hot accept strobe.
REQ-010 Port rsp_valid, output, 1 bit: result available.
REQ-011 Port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port rsp_parity, output, 1 bit: XOR of all WORD_W bits of the granted word.
REQ-013 Port rsp_id, output, IDW bits: index of the requester that owns the result.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL use one shared 5-input XOR unit and evaluate one 5-bit chunk per clock.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN when any req_valid bit is set.
- RUN->DONE after chunk NCHUNK-1.
- DONE->IDLE on rsp_valid & rsp_ready.
REQ-017 In IDLE, grant SHALL be round-robin: search begins at last_grant+1 modulo NREQ, and the first set req_valid bit wins.
REQ-018 req_ready[g] SHALL be asserted combinationally only in IDLE and only for the granted g; the transfer occurs on that edge.
REQ-019 On accept, the block SHALL register req_data slice g, set rsp_id = g, set last_grant = g, set chunk index = 0 and set acc = 0.
REQ-020 In RUN, each cycle SHALL perform acc <= acc ^ xor5(word[idx*5 +: 5]) and idx <= idx+1, with chunk 0 first (LSBs first).
REQ-021 rsp_valid SHALL rise NCHUNK+1 edges after the accept edge (5 for defaults).
- rsp_parity and rsp_id SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022 While busy, req_ready SHALL be all zero; requests from waiting requesters are held off and never dropped.
REQ-023 A requester that deasserts req_valid before being granted SHALL have no effect on the block.
REQ-024 The minimum issue interval SHALL be NCHUNK+2 cycles per word: IDLE, RUN×NCHUNK, DONE.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force the following, even mid-RUN or mid-DONE:
- state = IDLE;
- req_ready = 0, rsp_valid = 0, rsp_parity = 0, rsp_id = 0, busy = 0;
- acc = 0 and idx = 0;
- last_grant = NREQ-1, so requester 0 wins first after reset.
REQ-026 A word in flight at reset SHALL be discarded and SHALL produce no response after release.

Configuration
REQ-027 Macro XOR5_SCHED_WORD_CNT_EN, when defined, SHALL add output word_cnt, 16 bits.
- It increments on each rsp_valid & rsp_ready handshake, wraps 0xFFFF->0x0000 and resets to 0.
- When the macro is undefined, the port and counter SHALL be absent and all other behaviour is identical.

Structure
REQ-028 Package xor5_sched_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the CHUNK_W=5 constant.
REQ-029 Sub-module xor5_unit, with 5-bit input and 1-bit output, SHALL hold the shared XOR and be instantiated once.
REQ-030 Elaboration SHALL fail if WORD_W%5 != 0 or NREQ is outside 2..4.

Verification (WORD_W=20, NREQ=2)
REQ-031 req0 sends 0x00001, rsp_ready=1 -> rsp_valid after 5 edges, rsp_parity=1, rsp_id=0.
REQ-032 req1 sends 0xFFFFF -> rsp_parity=0, rsp_id=1; then req1 sends 0x80000 -> rsp_parity=1.
REQ-033 Both req_valid held high for 4 words -> rsp_id sequence 0,1,0,1.
REQ-034 rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_parity and rsp_id stable, req_ready=00, busy=1.
REQ-035 rst_n pulsed low at RUN cycle 2 -> all outputs 0 immediately; no rsp_valid within 10 cycles after release without new requests.
REQ-036 With XOR5_SCHED_WORD_CNT_EN defined, 3 completed words -> word_cnt=3.
- With word_cnt preloaded to 0xFFFF via force, one more completed word -> 0x0000.

Source files
------------

// File: rtl/xor5_sched_pkg.sv
// Shared constants, FSM state encoding and width helper for the xor5 parity scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xor5_sched_pkg;

    localparam int CHUNK_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int sched_idw(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/xor5_parity_sched_if.sv
// Request/response bundle between requesters, the parity scheduler and its consumer.
// Latency: n/a (wiring only).
// Backpressure: req_ready is a one-hot accept strobe; rsp_ready stalls the result.
interface xor5_parity_sched_if #(
    parameter int WORD_W = 20,
    parameter int NREQ   = 2
) ();
    localparam int IDW = xor5_sched_pkg::sched_idw(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORD_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_parity;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_parity, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_parity, rsp_id, busy
    );
endinterface

// File: rtl/xor5_unit.sv
// Shared 5-input XOR reduction used once per chunk.
// Latency: combinational.
// Backpressure: none.
module xor5_unit
    import xor5_sched_pkg::*;
(
    input  logic [CHUNK_W-1:0] din,
    output logic               dout
);
    assign dout = ^din;
endmodule

// File: rtl/xor5_parity_sched.sv
// Round-robin arbiter feeding one word at a time through a shared 5-bit XOR unit; optional word_cnt via XOR5_SCHED_WORD_CNT_EN.
// Latency: result valid NCHUNK edges after the accept edge; one word per NCHUNK+2 cycles at best.
// Backpressure: holds the result while rsp_ready is low; req_ready stays low until the result is taken.
module xor5_parity_sched
    import xor5_sched_pkg::*;
#(
    parameter int WORD_W = 20,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    xor5_parity_sched_if.slave     bus
`ifdef XOR5_SCHED_WORD_CNT_EN
    ,
    output logic [15:0]            word_cnt
`endif
);
    localparam int NCHUNK = WORD_W / CHUNK_W;
    localparam int IDW    = sched_idw(NREQ);
    localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0]     S_IDLE    = IDLE;
    localparam logic [1:0]     S_RUN     = RUN;
    localparam logic [1:0]     S_DONE    = DONE;
    localparam logic [CIW-1:0] LAST_IDX  = CIW'(NCHUNK - 1);
    localparam logic [IDW-1:0] RST_GRANT = IDW'(NREQ - 1);

    generate
        if ((WORD_W % CHUNK_W) != 0 || NREQ < 2 || NREQ > 4) begin : g_bad_param
            $error("xor5_parity_sched: WORD_W must be a multiple of 5 and NREQ within 2..4");
        end
    endgenerate

    logic [1:0]        state;
    logic [WORD_W-1:0] word_q;
    logic [CIW-1:0]    idx;
    logic              acc;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    last_grant;

    logic              gnt_vld;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW-1:0]    cand;
    logic [NREQ-1:0]   req_ready_w;
    logic [CHUNK_W-1:0] chunk;
    logic              chunk_x;
    logic              accept;
    logic              rsp_hs;

    // Rotating priority: the requester after the last grant is tried first.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!gnt_vld && bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // rst_n gates the strobe so nothing looks accepted while reset is held.
    assign accept = rst_n && (state == S_IDLE) && gnt_vld;
    assign rsp_hs = (state == S_DONE) && bus.rsp_ready;

    always_comb begin
        req_ready_w = '0;
        if (accept) begin
            req_ready_w[gnt_idx] = 1'b1;
        end
    end

    assign chunk = word_q[idx*CHUNK_W +: CHUNK_W];

    xor5_unit u_xor5 (
        .din  (chunk),
        .dout (chunk_x)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            word_q     <= '0;
            idx        <= '0;
            acc        <= 1'b0;
            id_q       <= '0;
            last_grant <= RST_GRANT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        word_q     <= bus.req_data[gnt_idx*WORD_W +: WORD_W];
                        id_q       <= gnt_idx;
                        last_grant <= gnt_idx;
                        idx        <= '0;
                        acc        <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc ^ chunk_x;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + CIW'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_hs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.rsp_valid  = (state == S_DONE);
    assign bus.rsp_parity = acc;
    assign bus.rsp_id     = id_q;
    assign bus.busy       = (state != S_IDLE);

`ifdef XOR5_SCHED_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= 16'd0;
        end else if (rsp_hs) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_xor5_parity_sched.sv
// Directed bench for xor5_parity_sched with a transaction-level reference model checked every cycle.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls and held-off requesters.
module tb_xor5_parity_sched;
    localparam int WORD_W = 20;
    localparam int NREQ   = 2;
    localparam int NCHUNK = WORD_W / 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xor5_parity_sched_if #(.WORD_W(WORD_W), .NREQ(NREQ)) bus ();

`ifdef XOR5_SCHED_WORD_CNT_EN
    logic [15:0] word_cnt;
`endif

    xor5_parity_sched #(.WORD_W(WORD_W), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef XOR5_SCHED_WORD_CNT_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference model: a word is either absent or in flight with a cycle age.
    bit              m_free = 1'b1;
    int              m_age  = 0;
    logic [WORD_W-1:0] m_word = '0;
    int              m_id   = 0;
    int              m_last = NREQ - 1;
    int              m_hs_rst = 0;
    int              c_g;
    logic [NREQ-1:0] c_rdy;
    bit              c_vld;

    int dut_id_q[$];
    int dut_par_q[$];

    // Set only by the stimulus process when word_cnt is preloaded.
    int wc_pre_val = 0;
    int wc_pre_hs  = 0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_parity", bus.rsp_parity, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
`ifdef XOR5_SCHED_WORD_CNT_EN
            chk("rst_word_cnt", word_cnt, 0);
`endif
            m_free   = 1'b1;
            m_age    = 0;
            m_last   = NREQ - 1;
            m_hs_rst = 0;
        end else begin
            if (m_free) begin
                c_g   = rr_pick(bus.req_valid, m_last);
                c_rdy = (c_g >= 0) ? NREQ'(1 << c_g) : '0;
                c_vld = 1'b0;
            end else begin
                c_g   = -1;
                c_rdy = '0;
                c_vld = (m_age >= NCHUNK);
            end
            chk("req_ready", bus.req_ready, c_rdy);
            chk("busy", bus.busy, !m_free);
            chk("rsp_valid", bus.rsp_valid, c_vld);
            if (c_vld) begin
                chk("rsp_parity", bus.rsp_parity, ^m_word);
                chk("rsp_id", bus.rsp_id, m_id);
            end
`ifdef XOR5_SCHED_WORD_CNT_EN
            chk("word_cnt", word_cnt, 16'(wc_pre_val + m_hs_rst - wc_pre_hs));
`endif
            if (bus.rsp_valid && bus.rsp_ready) begin
                dut_id_q.push_back(int'(bus.rsp_id));
                dut_par_q.push_back(int'(bus.rsp_parity));
            end
            // Advance the model across the coming rising edge.
            if (m_free) begin
                if (c_g >= 0) begin
                    m_free = 1'b0;
                    m_age  = 0;
                    m_word = bus.req_data[c_g*WORD_W +: WORD_W];
                    m_id   = c_g;
                    m_last = c_g;
                end
            end else if (c_vld && bus.rsp_ready) begin
                m_free = 1'b1;
                m_hs_rst++;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [WORD_W-1:0] d);
        bit got = 1'b0;
        bus.req_data[r*WORD_W +: WORD_W] = d;
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = bus.req_ready[r];
            tick();
        end
        bus.req_valid[r] = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 100 && dut_id_q.size() < n; i++) tick();
        if (dut_id_q.size() < n) chk("rsp_timeout", dut_id_q.size(), n);
    endtask

    initial begin
        int edges;
        int k;
        int n0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // Reset, with requests already waiting: nothing may be accepted.
        bus.req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        // Single word from requester 0; count edges from the accept edge inclusive.
        send(0, 20'h00001);
        edges = 1;
        while (!bus.rsp_valid && edges < 20) begin
            tick();
            edges++;
        end
        chk("latency_edges", edges, NCHUNK + 1);
        wait_rsp(1);
        chk("t1_id", dut_id_q[0], 0);
        chk("t1_parity", dut_par_q[0], 1);

        send(1, 20'hFFFFF);
        wait_rsp(2);
        chk("t2_id", dut_id_q[1], 1);
        chk("t2_parity", dut_par_q[1], 0);
        send(1, 20'h80000);
        wait_rsp(3);
        chk("t3_id", dut_id_q[2], 1);
        chk("t3_parity", dut_par_q[2], 1);

        // Both requesters held high across four grants.
        bus.req_data  = {20'h00007, 20'h00003};
        bus.req_valid = 2'b11;
        k = 0;
        for (int i = 0; i < 100 && k < 4; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) k++;
            tick();
        end
        bus.req_valid = 2'b00;
        chk("rr_grants", k, 4);
        wait_rsp(7);
        chk("rr_id0", dut_id_q[3], 0);
        chk("rr_id1", dut_id_q[4], 1);
        chk("rr_id2", dut_id_q[5], 0);
        chk("rr_id3", dut_id_q[6], 1);
        chk("rr_par0", dut_par_q[3], 0);
        chk("rr_par1", dut_par_q[4], 1);

        // Consumer stall in DONE while requester 1 waits.
        bus.rsp_ready = 1'b0;
        send(0, 20'h0001F);
        bus.req_data[WORD_W +: WORD_W] = 20'h00010;
        bus.req_valid[1] = 1'b1;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_parity", bus.rsp_parity, 1);
            chk("stall_id", bus.rsp_id, 0);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_busy", bus.busy, 1);
        end
        bus.rsp_ready = 1'b1;
        wait_rsp(8);
        chk("stall_rsp_id", dut_id_q[7], 0);
        chk("stall_rsp_parity", dut_par_q[7], 1);
        k = 0;
        for (int i = 0; i < 30 && k == 0; i++) begin
            @(negedge clk);
            if (bus.req_ready[1]) k = 1;
            tick();
        end
        bus.req_valid[1] = 1'b0;
        chk("held_req_granted", k, 1);
        wait_rsp(9);
        chk("held_rsp_id", dut_id_q[8], 1);

        // Reset in the second RUN cycle discards the word.
        send(0, 20'h12345);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_parity", bus.rsp_parity, 0);
        chk("mid_rst_id", bus.rsp_id, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = dut_id_q.size();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_no_valid", bus.rsp_valid, 0);
        end
        chk("post_rst_no_rsp", dut_id_q.size(), n0);

        // After reset requester 0 wins first.
        bus.req_data  = {20'h00001, 20'h00001};
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_first_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(n0 + 1);
        chk("post_rst_id", dut_id_q[n0], 0);

        send(0, 20'h00002);
        wait_rsp(n0 + 2);
        send(1, 20'h00003);
        wait_rsp(n0 + 3);
`ifdef XOR5_SCHED_WORD_CNT_EN
        chk("word_cnt_three", word_cnt, 3);
        wc_pre_hs  = m_hs_rst;
        wc_pre_val = 16'hFFFF;
        force dut.word_cnt_q = 16'hFFFF;
        #1;
        release dut.word_cnt_q;
        tick();
        send(0, 20'h00001);
        wait_rsp(n0 + 4);
        chk("word_cnt_wrap", word_cnt, 0);
`endif
        chk("final_id", dut_id_q[n0 + 2], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        n_total++;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
